// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants, state encodings and types for the instruction-fetch controller.
package pc_fetch_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            valid;
  } skid_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_skid_buf.sv
// Single-entry {inst, pc, valid} buffer that parks a word fetched while the
// decode stage is stalled. Clear wins over load, load wins over unload.
module pc_fetch_ctrl_skid_buf
  import pc_fetch_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic            unload_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  output skid_entry_t     entry_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_o <= '0;
    end else if (clear_i) begin
      entry_o.valid <= 1'b0;
    end else if (load_i) begin
      entry_o.inst  <= inst_i;
      entry_o.pc    <= pc_i;
      entry_o.valid <= 1'b1;
    end else if (unload_i) begin
      entry_o.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-memory fetch handshake feeding IF/ID; takes
// EX-stage redirects, flushes the wrong path and honours load-use stalls.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no request
// FETCH | request at addr, accepted words go straight to IF/ID
// HOLD  | word parked in skid buffer while decode is stalled, no request
// DRAIN | finishing an un-acked request after a redirect, data is discarded
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSN = DEF_NOP_INSN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            inst_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] redirect_cnt_o
);

  logic [1:0]      state;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] drain_target;
  logic [XLEN-1:0] target_aligned;
  logic            fire;
  logic            skid_load;
  logic            skid_unload;
  skid_entry_t     skid;

  assign imem_req_o     = (state == ST_FETCH) || (state == ST_DRAIN);
  assign imem_addr_o    = addr;
  assign fire           = imem_req_o && imem_ack_i;
  assign target_aligned = word_align(target_i);
  assign flush_o        = pc_sel_i && !rst_i;

  assign skid_load   = !pc_sel_i && (state == ST_FETCH) && fire && stall_i;
  assign skid_unload = !pc_sel_i && (state == ST_HOLD) && !stall_i;

  pc_fetch_ctrl_skid_buf u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (skid_load),
    .clear_i  (pc_sel_i),
    .unload_i (skid_unload),
    .inst_i   (imem_rdata_i),
    .pc_i     (addr),
    .entry_o  (skid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_BOOT;
      addr           <= RESET_PC;
      drain_target   <= RESET_PC;
      inst_o         <= NOP_INSN;
      pc_o           <= RESET_PC;
      inst_valid_o   <= 1'b0;
      misalign_o     <= 1'b0;
      redirect_cnt_o <= '0;
    end else begin
      misalign_o <= 1'b0;
      if (pc_sel_i) begin
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
        inst_valid_o   <= 1'b0;
        inst_o         <= NOP_INSN;
        misalign_o     <= |target_i[1:0];
        // An outstanding request must keep its address until it is acked.
        if (imem_req_o && !imem_ack_i) begin
          drain_target <= target_aligned;
          state        <= ST_DRAIN;
        end else begin
          addr  <= target_aligned;
          state <= ST_FETCH;
        end
      end else begin
        case (state)
          ST_BOOT: begin
            state <= ST_FETCH;
          end
          ST_FETCH: begin
            if (fire) begin
              if (stall_i) begin
                state <= ST_HOLD;
              end else begin
                inst_o       <= imem_rdata_i;
                pc_o         <= addr;
                inst_valid_o <= 1'b1;
                addr         <= addr + 32'd4;
              end
            end else if (!stall_i) begin
              inst_o       <= NOP_INSN;
              inst_valid_o <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!stall_i) begin
              inst_o       <= skid.inst;
              pc_o         <= skid.pc;
              inst_valid_o <= skid.valid;
              addr         <= skid.pc + 32'd4;
              state        <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (imem_ack_i) begin
              addr  <= drain_target;
              state <= ST_FETCH;
            end
          end
          default: state <= ST_BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: boot, wait states, redirect/drain, stall/hold,
// misaligned target, PC wrap and asynchronous reset in the middle of a drain.
module tb_pc_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_sel_i;
  logic [31:0] target_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] redirect_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  pc_fetch_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_sel_i       (pc_sel_i),
    .target_i       (target_i),
    .stall_i        (stall_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .inst_o         (inst_o),
    .pc_o           (pc_o),
    .inst_valid_o   (inst_valid_o),
    .flush_o        (flush_o),
    .misalign_o     (misalign_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory content is a fixed function of the address being fetched.
  assign imem_rdata_i = mem_word(imem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req_o},   32'd0);
    chk({tag, "_addr"},  imem_addr_o,           32'h0);
    chk({tag, "_inst"},  inst_o,                NOP);
    chk({tag, "_pc"},    pc_o,                  32'h0);
    chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush_o},      32'd0);
    chk({tag, "_mis"},   {31'd0, misalign_o},   32'd0);
    chk({tag, "_cnt"},   redirect_cnt_o,        32'd0);
  endtask

  initial begin
    rst_i = 1'b1; pc_sel_i = 1'b0; target_i = 32'h0; stall_i = 1'b0; imem_ack_i = 1'b0;
    tick(); tick();
    chk_reset_values("rst");

    // Boot with zero-wait memory
    imem_ack_i = 1'b1;
    rst_i = 1'b0;
    tick();
    chk("boot_req",   {31'd0, imem_req_o},   32'd1);
    chk("boot_addr",  imem_addr_o,           32'h0);
    chk("boot_valid", {31'd0, inst_valid_o}, 32'd0);
    tick();
    chk("b2b_pc0",    pc_o,                  32'h0);
    chk("b2b_inst0",  inst_o,                mem_word(32'h0));
    chk("b2b_valid0", {31'd0, inst_valid_o}, 32'd1);
    tick();
    chk("b2b_pc4", pc_o, 32'h4);
    tick();
    chk("b2b_pc8", pc_o, 32'h8);
    tick();
    chk("b2b_pcc", pc_o, 32'hC);

    // Wait states at 0x10
    imem_ack_i = 1'b0;
    chk("ws_addr0", imem_addr_o, 32'h10);
    tick();
    chk("ws_addr1",  imem_addr_o,           32'h10);
    chk("ws_valid1", {31'd0, inst_valid_o}, 32'd0);
    chk("ws_req1",   {31'd0, imem_req_o},   32'd1);
    tick();
    chk("ws_addr2", imem_addr_o, 32'h10);
    tick();
    chk("ws_addr3", imem_addr_o, 32'h10);
    imem_ack_i = 1'b1;
    tick();
    chk("ws_pc",    pc_o,                  32'h10);
    chk("ws_inst",  inst_o,                mem_word(32'h10));
    chk("ws_valid", {31'd0, inst_valid_o}, 32'd1);
    tick();
    chk("pre_rd_pc",   pc_o,        32'h14);
    chk("pre_rd_addr", imem_addr_o, 32'h18);

    // Redirect to 0x200 with an un-acked request at 0x18
    imem_ack_i = 1'b0; pc_sel_i = 1'b1; target_i = 32'h200;
    #1;
    chk("rd_flush", {31'd0, flush_o}, 32'd1);
    tick();
    chk("drain_cnt",   redirect_cnt_o,        32'd1);
    chk("drain_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("drain_inst",  inst_o,                NOP);
    chk("drain_addr",  imem_addr_o,           32'h18);
    chk("drain_req",   {31'd0, imem_req_o},   32'd1);
    pc_sel_i = 1'b0;
    #1;
    chk("drain_flush0", {31'd0, flush_o}, 32'd0);
    imem_ack_i = 1'b1;
    tick();
    chk("after_drain_addr",  imem_addr_o,           32'h200);
    chk("after_drain_valid", {31'd0, inst_valid_o}, 32'd0);
    tick();
    chk("tgt_pc",    pc_o,                  32'h200);
    chk("tgt_valid", {31'd0, inst_valid_o}, 32'd1);

    // Redirect while the request is acked: straight to FETCH at target
    pc_sel_i = 1'b1; target_i = 32'h1C;
    tick();
    chk("rd_ack_addr",  imem_addr_o,           32'h1C);
    chk("rd_ack_cnt",   redirect_cnt_o,        32'd2);
    chk("rd_ack_valid", {31'd0, inst_valid_o}, 32'd0);
    pc_sel_i = 1'b0;
    tick();
    chk("pre_stall_pc", pc_o, 32'h1C);

    // Stall for two cycles while 0x20 is acked
    stall_i = 1'b1;
    tick();
    chk("hold_req1",   {31'd0, imem_req_o},   32'd0);
    chk("hold_pc1",    pc_o,                  32'h1C);
    chk("hold_valid1", {31'd0, inst_valid_o}, 32'd1);
    tick();
    chk("hold_req2",  {31'd0, imem_req_o}, 32'd0);
    chk("hold_pc2",   pc_o,                32'h1C);
    chk("hold_inst2", inst_o,              mem_word(32'h1C));
    stall_i = 1'b0;
    tick();
    chk("unload_pc",    pc_o,                  32'h20);
    chk("unload_inst",  inst_o,                mem_word(32'h20));
    chk("unload_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("unload_addr",  imem_addr_o,           32'h24);
    chk("unload_req",   {31'd0, imem_req_o},   32'd1);
    tick();
    chk("post_hold_pc", pc_o, 32'h24);

    // Misaligned target
    pc_sel_i = 1'b1; target_i = 32'h103;
    tick();
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_addr",  imem_addr_o,         32'h100);
    chk("mis_cnt",   redirect_cnt_o,      32'd3);
    pc_sel_i = 1'b0;
    tick();
    chk("mis_clear", {31'd0, misalign_o}, 32'd0);
    chk("mis_pc",    pc_o,                32'h100);

    // PC wrap
    pc_sel_i = 1'b1; target_i = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", imem_addr_o,         32'hFFFF_FFFC);
    chk("wrap_cnt",  redirect_cnt_o,      32'd4);
    chk("wrap_mis",  {31'd0, misalign_o}, 32'd0);
    pc_sel_i = 1'b0;
    tick();
    chk("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc0",    pc_o,                  32'h0);
    chk("wrap_valid",  {31'd0, inst_valid_o}, 32'd1);

    // Redirect during DRAIN overwrites the latched target
    imem_ack_i = 1'b0; pc_sel_i = 1'b1; target_i = 32'h300;
    tick();
    chk("d2_cnt",  redirect_cnt_o,      32'd5);
    chk("d2_addr", imem_addr_o,         32'h4);
    chk("d2_req",  {31'd0, imem_req_o}, 32'd1);
    target_i = 32'h400;
    tick();
    chk("d2_cnt2",  redirect_cnt_o, 32'd6);
    chk("d2_addr2", imem_addr_o,    32'h4);
    pc_sel_i = 1'b0; imem_ack_i = 1'b1;
    tick();
    chk("d2_final_addr", imem_addr_o,           32'h400);
    chk("d2_valid",      {31'd0, inst_valid_o}, 32'd0);

    // Asynchronous reset in the middle of a drain
    imem_ack_i = 1'b0; pc_sel_i = 1'b1; target_i = 32'h500;
    tick();
    chk("d3_cnt",  redirect_cnt_o,      32'd7);
    chk("d3_addr", imem_addr_o,         32'h400);
    chk("d3_req",  {31'd0, imem_req_o}, 32'd1);
    pc_sel_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_values("arst");

    tick();
    rst_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Consumer end of the branch/jump decision. Owns the program counter and the instruction-memory fetch handshake for the RV32IM pipeline.
- Accepts the taken/not-taken decision (pc_sel_i) and target from the EX-stage branch comparator, redirects fetch, and flushes the wrong-path instructions.
- Honours load-use stalls from the hazard unit.
- Feeds the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSN, 32'h0000_0013, instruction driven while inst_valid_o is 0 (addi x0,x0,0).

Ports:
- clk_i  in  1  single clock, all flops rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- pc_sel_i  in  1  branch/jump taken, from EX comparator.
- target_i  in  32  redirect target, qualified by pc_sel_i.
- stall_i  in  1  hold IF/ID outputs (load-use hazard).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_ack_i  in  1  request accepted; data valid this cycle.
- imem_rdata_i  in  32  fetched instruction.
- inst_o  out  32  instruction to IF/ID.
- pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o/pc_o hold a live instruction.
- flush_o  out  1  one-cycle kill of IF/ID and ID/EX.
- misalign_o  out  1  one-cycle pulse, target_i[1:0] != 0 on a taken redirect.
- redirect_cnt_o  out  32  count of taken redirects.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC
  - inst_o=NOP_INSN, pc_o=RESET_PC, inst_valid_o=0
  - flush_o=0, misalign_o=0, redirect_cnt_o=0
  - state=BOOT
- Memory sharing rule: instruction memory shares rst_i, so no stale ack can arrive after reset.
- Handshake:
  - imem_req_o stays high with imem_addr_o stable until imem_ack_i.
  - ack may arrive in the same cycle req rises (zero wait) or any later cycle.
  - Data is sampled only on req&&ack.
- States:
  - BOOT: one cycle after reset release -> FETCH with req=1 at RESET_PC.
  - FETCH: req=1.
    - On ack with stall_i=0: next cycle inst_o=rdata, pc_o=addr, inst_valid_o=1, addr+=4, stay FETCH (back-to-back, 1 instr/cycle at zero wait).
    - On ack with stall_i=1: rdata/addr go to the skid buffer, req drops, -> HOLD.
  - HOLD: req=0, outputs frozen. When stall_i falls, buffer moves to outputs next cycle -> FETCH at buffered addr+4.
  - DRAIN: req=1 at the old address, entered on redirect with an un-acked request. On ack, data is discarded -> FETCH at the redirect target.
- Redirect (pc_sel_i=1):
  - Priority over stall_i and any pending fetch.
  - Same cycle: flush_o=1 (combinational).
  - Next edge: inst_valid_o=0, inst_o=NOP_INSN, redirect_cnt_o+=1, skid buffer cleared.
  - Target address = {target_i[31:2],2'b00}.
  - misalign_o=1 for one cycle if target_i[1:0] != 0.
  - If req high and no ack this cycle -> latch target, go to DRAIN (address must not change mid-request).
  - If ack this cycle or req low -> go to FETCH at target next cycle. Returned data is dropped.
- Redirect during DRAIN: the newer target overwrites the latched target; counter increments again.
- Stall with no fetch activity: outputs hold; req may stay asserted in FETCH, but an acked word goes to HOLD.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- redirect_cnt_o wraps modulo 2^32.
- Reset mid-DRAIN or HOLD: immediate return to reset values; latched target and buffer are lost.

Decomposition:
- Shared defines file (cpu_defs.vh):
  - NOP_INSN, RESET_PC defaults
  - state encodings BOOT/FETCH/HOLD/DRAIN (2-bit)
  - XLEN=32
- One sub-module: fetch_skid_buf, a single-entry {inst,pc,valid} buffer with load, clear, unload.

Test Plan:
- Reset release, ack tied high -> req at 0x0, then pc_o 0x0, 0x4, 0x8 on consecutive cycles, inst_valid_o=1 from cycle 2.
- Ack delayed 3 cycles while addr=0x10 -> imem_addr_o stable at 0x10 for 4 cycles; single inst at pc_o=0x10.
- pc_sel_i=1, target_i=0x200, un-acked request at 0x18 -> flush_o 1 cycle, DRAIN, 0x18 data dropped, next req at 0x200, redirect_cnt_o=1.
- stall_i high 2 cycles with ack at 0x20 -> outputs frozen, req low in HOLD; after release pc_o=0x20, then 0x24.
- pc_sel_i with target_i=0x103 -> misalign_o pulse, fetch at 0x100.
- Redirect target 0xFFFF_FFFC, zero-wait memory -> next pc_o=0x0. Assert rst_i mid-DRAIN -> all outputs return to reset values asynchronously.
